cr_huf_comp_htb_dispatch: RTL and testbench

Parametrised job dispatcher that steers end-of-block tree-build jobs from the input-sort stage to one of NUM_PIPES `cr_huf_comp_htb` tree builders. It generalises the fixed two-pipe, pipe-1-first steering to N pipes, with a per-pipe disable mask and a selectable fixed-priority or round-robin arbitration mode. It also keeps an in-order dispatch record, so the downstream header writer consumes tree results in job order.

---
 rtl/cr_huf_compPKG.sv | 22 ++
 rtl/cr_huf_comp_htb_ord_fifo.sv | 63 ++++++
 rtl/cr_huf_comp_htb_dispatch.sv | 114 +++++++++++
 tb/tb_cr_huf_comp_htb_dispatch.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cr_huf_compPKG.sv
// Shared types for the Huffman compressor: pipe end-of-block encoding and the
// tree-build dispatch order-record entry.
package cr_huf_compPKG;

    localparam int CREOLE_HC_SEQID_WIDTH = 6;
    localparam int HTB_MAX_PIPE_WIDTH    = 3;

    typedef enum logic [1:0] {
        MIDDLE      = 2'd0,
        PASS_THRU   = 2'd1,
        MORE_BLOCKS = 2'd2,
        LAST_BLOCK  = 2'd3
    } e_pipe_eob;

    // Sized for the largest supported pipe count; narrower configurations
    // use the low bits of pipe.
    typedef struct packed {
        logic [HTB_MAX_PIPE_WIDTH-1:0]    pipe;
        logic [CREOLE_HC_SEQID_WIDTH-1:0] seq_id;
    } s_htb_ord_entry;

endpackage

// File: rtl/cr_huf_comp_htb_ord_fifo.sv
// Flop-based synchronous FIFO holding the in-order dispatch record.
// Pop while empty is dropped and reported as a one-cycle underflow pulse.
module cr_huf_comp_htb_ord_fifo #(
    parameter int  DEPTH = 8,
    parameter int  WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             underflow_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             underflow_q;
    logic             do_push;
    logic             do_pop;

    assign full_o      = (count_q == (AW+1)'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign do_push     = push_i & ~full_o;
    assign do_pop      = pop_i & ~empty_o;
    assign underflow_o = underflow_q;
    // Stale storage is hidden so the head reads as zero after reset or drain.
    assign rdata_o     = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
            underflow_q <= pop_i & empty_o;
        end
    end

endmodule

// File: rtl/cr_huf_comp_htb_dispatch.sv
// Steers end-of-block tree-build jobs to one of NUM_PIPES tree builders and
// records dispatch order so the header writer consumes results in job order.
module cr_huf_comp_htb_dispatch
    import cr_huf_compPKG::*;
#(
    parameter int  NUM_PIPES   = 4,
    parameter int  SEQID_WIDTH = CREOLE_HC_SEQID_WIDTH,
    parameter int  ORD_DEPTH   = 8,
    parameter int  RR_MODE     = 1,
    localparam int PIPE_W      = $clog2(NUM_PIPES)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  e_pipe_eob                             in_eob,
    input  logic [SEQID_WIDTH-1:0]                in_seq_id,
    output logic                                  in_not_ready,
    input  logic [NUM_PIPES-1:0]                  pipe_not_ready,
    input  logic [NUM_PIPES-1:0]                  sw_disable_mask,
    output e_pipe_eob [NUM_PIPES-1:0]             pipe_eob,
    output logic [NUM_PIPES-1:0][SEQID_WIDTH-1:0] pipe_seq_id,
    output logic                                  ord_valid,
    output logic [PIPE_W-1:0]                     ord_pipe,
    output logic [SEQID_WIDTH-1:0]                ord_seq_id,
    input  logic                                  ord_pop,
    output logic [NUM_PIPES-1:0]                  dbg_dispatch,
    output logic                                  ord_underflow
);

    localparam int ENTRY_W = PIPE_W + SEQID_WIDTH;

    logic [NUM_PIPES-1:0] dis_q;
    logic [NUM_PIPES-1:0] dbg_dispatch_q;
    logic [PIPE_W-1:0]    rr_ptr_q;
    logic [PIPE_W-1:0]    rr_ptr_d;
    logic [NUM_PIPES-1:0] elig;
    logic [NUM_PIPES-1:0] grant;
    logic [PIPE_W-1:0]    sel;
    logic                 sel_found;
    logic                 job;
    logic                 dispatch;
    logic                 ord_full;
    logic                 ord_empty;
    logic [ENTRY_W-1:0]   ord_head;
    int                   idx;

    assign elig         = ~pipe_not_ready & ~dis_q;
    assign in_not_ready = ~rst_n | ~(|elig) | ord_full;
    assign job          = (in_eob != MIDDLE);
    assign dispatch     = job & ~in_not_ready & sel_found;

    // Scan starts at rr_ptr in round-robin mode, index 0 in fixed mode; the
    // first eligible pipe met while wrapping around wins.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            idx = (RR_MODE != 0) ? int'(rr_ptr_q) + i : i;
            if (idx >= NUM_PIPES) begin
                idx = idx - NUM_PIPES;
            end
            if (!sel_found && elig[idx]) begin
                sel       = PIPE_W'(idx);
                sel_found = 1'b1;
            end
        end
    end

    assign rr_ptr_d = (sel == PIPE_W'(NUM_PIPES - 1)) ? '0 : sel + PIPE_W'(1);

    generate
        for (genvar gi = 0; gi < NUM_PIPES; gi++) begin : g_pipe
            assign grant[gi]       = dispatch && (sel == PIPE_W'(gi));
            assign pipe_eob[gi]    = grant[gi] ? in_eob : MIDDLE;
            assign pipe_seq_id[gi] = grant[gi] ? in_seq_id : '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dis_q          <= '0;
            rr_ptr_q       <= '0;
            dbg_dispatch_q <= '0;
        end else begin
            dis_q          <= sw_disable_mask;
            dbg_dispatch_q <= grant;
            if (dispatch) begin
                rr_ptr_q <= rr_ptr_d;
            end
        end
    end

    assign dbg_dispatch = dbg_dispatch_q;

    cr_huf_comp_htb_ord_fifo #(
        .DEPTH (ORD_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ord_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (dispatch),
        .pop_i       (ord_pop),
        .wdata_i     ({sel, in_seq_id}),
        .rdata_o     (ord_head),
        .full_o      (ord_full),
        .empty_o     (ord_empty),
        .underflow_o (ord_underflow)
    );

    assign ord_valid  = ~ord_empty;
    assign ord_pipe   = ord_head[ENTRY_W-1:SEQID_WIDTH];
    assign ord_seq_id = ord_head[SEQID_WIDTH-1:0];

endmodule

// File: tb/tb_cr_huf_comp_htb_dispatch.sv
// Bench for the tree-build dispatcher: a round-robin and a fixed-priority
// instance share stimulus and are checked against a queue-based job model.
module tb_cr_huf_comp_htb_dispatch;
    import cr_huf_compPKG::*;

    localparam int N  = 4;
    localparam int SW = 6;
    localparam int D  = 8;
    localparam int PW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    e_pipe_eob            in_eob;
    logic [SW-1:0]        in_seq_id;
    logic [N-1:0]         pipe_not_ready;
    logic [N-1:0]         sw_disable_mask;
    logic                 ord_pop;

    logic                 nr_r, nr_f;
    e_pipe_eob [N-1:0]    peob_r, peob_f;
    logic [N-1:0][SW-1:0] pseq_r, pseq_f;
    logic                 ov_r, ov_f;
    logic [PW-1:0]        op_r, op_f;
    logic [SW-1:0]        os_r, os_f;
    logic [N-1:0]         dbg_r, dbg_f;
    logic                 uf_r, uf_f;

    cr_huf_comp_htb_dispatch #(.NUM_PIPES(N), .SEQID_WIDTH(SW), .ORD_DEPTH(D), .RR_MODE(1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .in_eob(in_eob), .in_seq_id(in_seq_id), .in_not_ready(nr_r),
        .pipe_not_ready(pipe_not_ready), .sw_disable_mask(sw_disable_mask),
        .pipe_eob(peob_r), .pipe_seq_id(pseq_r), .ord_valid(ov_r), .ord_pipe(op_r),
        .ord_seq_id(os_r), .ord_pop(ord_pop), .dbg_dispatch(dbg_r), .ord_underflow(uf_r));

    cr_huf_comp_htb_dispatch #(.NUM_PIPES(N), .SEQID_WIDTH(SW), .ORD_DEPTH(D), .RR_MODE(0)) dut_fx (
        .clk(clk), .rst_n(rst_n), .in_eob(in_eob), .in_seq_id(in_seq_id), .in_not_ready(nr_f),
        .pipe_not_ready(pipe_not_ready), .sw_disable_mask(sw_disable_mask),
        .pipe_eob(peob_f), .pipe_seq_id(pseq_f), .ord_valid(ov_f), .ord_pipe(op_f),
        .ord_seq_id(os_f), .ord_pop(ord_pop), .dbg_dispatch(dbg_f), .ord_underflow(uf_f));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mask seen by the arbiter, round-robin start, and the
    // outstanding-job lists for each arbitration flavour.
    logic [N-1:0]  m_dis = '0;
    int            m_rr = 0;
    int            qr_p[$];
    int            qf_p[$];
    int            q_seq[$];
    logic [N-1:0]  m_dbg_r = '0, m_dbg_f = '0;
    logic          m_uf = 1'b0;

    logic          e_nr, e_disp;
    int            e_sel_r, e_sel_f;
    e_pipe_eob     d_eob;
    logic [SW-1:0] d_seq;
    logic          d_pop, d_rn;
    logic [N-1:0]  d_mask;

    task automatic drive(input e_pipe_eob eob, input logic [SW-1:0] seq, input logic pop,
                         input logic [N-1:0] pnr, input logic [N-1:0] mask, input logic rn);
        logic [N-1:0] elig;
        in_eob = eob; in_seq_id = seq; ord_pop = pop;
        pipe_not_ready = pnr; sw_disable_mask = mask; rst_n = rn;
        d_eob = eob; d_seq = seq; d_pop = pop; d_mask = mask; d_rn = rn;
        #1;
        elig    = ~pnr & ~m_dis;
        e_nr    = !rn || (elig == '0) || (q_seq.size() == D);
        e_disp  = (eob != MIDDLE) && !e_nr;
        e_sel_f = -1;
        e_sel_r = -1;
        for (int i = 0; i < N; i++) begin
            if (e_sel_f < 0 && elig[i]) e_sel_f = i;
            if (e_sel_r < 0 && elig[(m_rr + i) % N]) e_sel_r = (m_rr + i) % N;
        end
    endtask

    task automatic tick();
        if (!d_rn) begin
            m_dis = '0; m_rr = 0; m_dbg_r = '0; m_dbg_f = '0; m_uf = 1'b0;
            qr_p.delete(); qf_p.delete(); q_seq.delete();
        end else begin
            m_uf = d_pop && (q_seq.size() == 0);
            if (d_pop && q_seq.size() > 0) begin
                void'(qr_p.pop_front()); void'(qf_p.pop_front()); void'(q_seq.pop_front());
            end
            m_dbg_r = '0;
            m_dbg_f = '0;
            if (e_disp) begin
                qr_p.push_back(e_sel_r); qf_p.push_back(e_sel_f); q_seq.push_back(int'(d_seq));
                m_rr = (e_sel_r + 1) % N;
                m_dbg_r[e_sel_r] = 1'b1;
                m_dbg_f[e_sel_f] = 1'b1;
                $display("dispatch seq=%0d eob=%0d rr_pipe=%0d fx_pipe=%0d depth=%0d",
                         d_seq, d_eob, e_sel_r, e_sel_f, q_seq.size());
            end
            m_dis = d_mask;
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * D && q_seq.size() > 0; i++) begin
            drive(MIDDLE, '0, 1'b1, '0, '0, 1'b1); tick();
        end
        drive(MIDDLE, '0, 1'b0, '0, '0, 1'b1); tick();
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            drive(LAST_BLOCK, SW'(9), 1'b0, '0, '0, 1'b0);
            n_checks++;
            if (nr_r !== 1'b1 || nr_f !== 1'b1) begin
                n_fail++; $display("FAIL reset_not_ready: got rr=%b fx=%b want 1", nr_r, nr_f);
            end
            n_checks++;
            if (peob_r !== {N{MIDDLE}} || peob_f !== {N{MIDDLE}} || pseq_r !== '0) begin
                n_fail++; $display("FAIL reset_pipe_idle: got eob=%h seq=%h want 0", peob_r, pseq_r);
            end
            tick();
        end
        drive(MIDDLE, '0, 1'b0, '0, '0, 1'b1);
        n_checks++;
        if ({ov_r, ov_f, op_r, os_r, dbg_r, dbg_f, uf_r, uf_f} !== '0) begin
            n_fail++; $display("FAIL reset_state: got ov=%b pipe=%0d seq=%0d dbg=%b uf=%b want all 0",
                               ov_r, op_r, os_r, dbg_r, uf_r);
        end
        tick();
    endtask

    task automatic test_rr_seq();
        int exp_p[5] = '{0, 1, 2, 3, 0};
        for (int j = 0; j < 5; j++) begin
            drive(e_pipe_eob'($urandom_range(1, 3)), SW'(j + 1), 1'b0, '0, '0, 1'b1);
            for (int k = 0; k < N; k++) begin
                n_checks++;
                if (k == exp_p[j] ? (peob_r[k] !== d_eob || pseq_r[k] !== d_seq)
                                  : (peob_r[k] !== MIDDLE || pseq_r[k] !== '0)) begin
                    n_fail++; $display("FAIL rr_steer job%0d pipe%0d: got eob=%0d seq=%0d want target pipe %0d",
                                       j + 1, k, peob_r[k], pseq_r[k], exp_p[j]);
                end
            end
            tick();
        end
        for (int j = 0; j < 5; j++) begin
            drive(MIDDLE, '0, 1'b1, '0, '0, 1'b1);
            n_checks++;
            if (ov_r !== 1'b1 || int'(op_r) != exp_p[j] || int'(os_r) != j + 1) begin
                n_fail++; $display("FAIL rr_order_head %0d: got v=%b (%0d,%0d) want (%0d,%0d)",
                                   j, ov_r, op_r, os_r, exp_p[j], j + 1);
            end
            tick();
        end
        drive(MIDDLE, '0, 1'b0, '0, '0, 1'b1);
        n_checks++;
        if (ov_r !== 1'b0) begin
            n_fail++; $display("FAIL rr_order_empty: got ord_valid=%b want 0", ov_r);
        end
        tick();
    endtask

    task automatic test_fixed();
        drive(PASS_THRU, SW'(7), 1'b0, 4'b0001, '0, 1'b1);
        for (int k = 0; k < N; k++) begin
            n_checks++;
            if (k == 1 ? (peob_f[k] !== PASS_THRU || pseq_f[k] !== SW'(7))
                       : (peob_f[k] !== MIDDLE || pseq_f[k] !== '0)) begin
                n_fail++; $display("FAIL fixed_steer pipe%0d: got eob=%0d seq=%0d want pipe 1 only",
                                   k, peob_f[k], pseq_f[k]);
            end
        end
        tick();
        drain();
    endtask

    task automatic test_mask();
        drive(MIDDLE, '0, 1'b0, '0, 4'b1110, 1'b1); tick();
        for (int j = 0; j < 3; j++) begin
            drive(MORE_BLOCKS, SW'(20 + j), 1'b0, '0, 4'b1110, 1'b1);
            n_checks++;
            if (peob_r[0] !== MORE_BLOCKS || peob_f[0] !== MORE_BLOCKS || nr_r !== 1'b0) begin
                n_fail++; $display("FAIL mask_pipe0 job%0d: got rr=%0d fx=%0d nr=%b want pipe 0",
                                   j, peob_r[0], peob_f[0], nr_r);
            end
            tick();
        end
        // The cycle the full mask is applied still uses the old mask.
        drive(MORE_BLOCKS, SW'(30), 1'b0, '0, 4'b1111, 1'b1);
        n_checks++;
        if (nr_r !== e_nr || peob_r[0] !== MORE_BLOCKS) begin
            n_fail++; $display("FAIL mask_change_cycle: got nr=%b eob0=%0d want 0/%0d", nr_r, peob_r[0], MORE_BLOCKS);
        end
        tick();
        for (int j = 0; j < 3; j++) begin
            drive(MORE_BLOCKS, SW'(31), 1'b0, '0, 4'b1111, 1'b1);
            n_checks++;
            if (nr_r !== 1'b1 || nr_f !== 1'b1 || peob_r !== {N{MIDDLE}}) begin
                n_fail++; $display("FAIL mask_all_hold: got nr=%b eob=%h want held", nr_r, peob_r);
            end
            n_checks++;
            if (ov_r !== 1'b1 || int'(os_r) != 20) begin
                n_fail++; $display("FAIL mask_record_kept: got v=%b seq=%0d want 1/20", ov_r, os_r);
            end
            tick();
        end
        for (int j = 0; j < 4; j++) begin
            drive(MORE_BLOCKS, SW'(31), 1'b1, '0, 4'b1111, 1'b1);
            n_checks++;
            if (ov_r !== 1'b1 || int'(os_r) != q_seq[0]) begin
                n_fail++; $display("FAIL mask_drain %0d: got v=%b seq=%0d want 1/%0d", j, ov_r, os_r, q_seq[0]);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_fill();
        for (int j = 0; j < D; j++) begin
            drive(LAST_BLOCK, SW'(40 + j), 1'b0, '0, '0, 1'b1);
            n_checks++;
            if (nr_r !== 1'b0) begin
                n_fail++; $display("FAIL fill_accept %0d: got not_ready=%b want 0", j, nr_r);
            end
            tick();
        end
        drive(LAST_BLOCK, SW'(48), 1'b1, '0, '0, 1'b1);
        n_checks++;
        if (nr_r !== 1'b1 || nr_f !== 1'b1 || peob_r !== {N{MIDDLE}} || peob_f !== {N{MIDDLE}}) begin
            n_fail++; $display("FAIL fill_full_block: got nr=%b/%b eob=%h want blocked", nr_r, nr_f, peob_r);
        end
        tick();
        drive(LAST_BLOCK, SW'(48), 1'b0, '0, '0, 1'b1);
        n_checks++;
        if (nr_r !== 1'b0 || peob_r[e_sel_r] !== LAST_BLOCK || int'(os_r) != 41) begin
            n_fail++; $display("FAIL fill_retry: got nr=%b eob=%h head=%0d want accept, head 41", nr_r, peob_r, os_r);
        end
        tick();
        drain();
    endtask

    task automatic test_underflow();
        drive(MIDDLE, '0, 1'b1, '0, '0, 1'b1); tick();
        drive(MIDDLE, '0, 1'b0, '0, '0, 1'b1);
        n_checks++;
        if (uf_r !== 1'b1 || uf_f !== 1'b1 || ov_r !== 1'b0) begin
            n_fail++; $display("FAIL underflow_pulse: got uf=%b/%b v=%b want 1/1/0", uf_r, uf_f, ov_r);
        end
        tick();
        drive(PASS_THRU, SW'(3), 1'b0, '0, '0, 1'b1);
        n_checks++;
        if (uf_r !== 1'b0 || ov_r !== 1'b0) begin
            n_fail++; $display("FAIL underflow_one_cycle: got uf=%b v=%b want 0/0", uf_r, ov_r);
        end
        tick();
        drive(MIDDLE, '0, 1'b0, '0, '0, 1'b1);
        n_checks++;
        if (ov_r !== 1'b1 || int'(os_r) != 3) begin
            n_fail++; $display("FAIL underflow_count_zero: got v=%b seq=%0d want 1/3", ov_r, os_r);
        end
        tick();
        drain();
    endtask

    task automatic test_reset_mid();
        for (int j = 0; j < 3; j++) begin
            drive(MORE_BLOCKS, SW'(50 + j), 1'b0, '0, '0, 1'b1); tick();
        end
        drive(MORE_BLOCKS, SW'(55), 1'b1, '0, '0, 1'b0);
        n_checks++;
        if (nr_r !== 1'b1 || peob_r !== {N{MIDDLE}}) begin
            n_fail++; $display("FAIL reset_mid_block: got nr=%b eob=%h want 1/idle", nr_r, peob_r);
        end
        tick();
        drive(LAST_BLOCK, SW'(60), 1'b0, '0, '0, 1'b1);
        n_checks++;
        if ({ov_r, ov_f, op_r, os_r, dbg_r, uf_r} !== '0) begin
            n_fail++; $display("FAIL reset_mid_cleared: got v=%b head=(%0d,%0d) dbg=%b uf=%b want 0",
                               ov_r, op_r, os_r, dbg_r, uf_r);
        end
        n_checks++;
        if (peob_r[0] !== LAST_BLOCK || pseq_r[0] !== SW'(60)) begin
            n_fail++; $display("FAIL reset_mid_rr_pipe0: got eob=%0d seq=%0d want %0d/60", peob_r[0], pseq_r[0], LAST_BLOCK);
        end
        tick();
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            e_pipe_eob    eob;
            logic [N-1:0] pnr, mask;
            eob  = ($urandom_range(0, 9) < 4) ? MIDDLE : e_pipe_eob'($urandom_range(1, 3));
            pnr  = N'($urandom) & N'($urandom);
            mask = ($urandom_range(0, 15) == 0) ? 4'b1111 : (N'($urandom) & N'($urandom) & N'($urandom));
            drive(eob, SW'($urandom), ($urandom_range(0, 9) < 4), pnr, mask, 1'b1);
            n_checks++;
            if (nr_r !== e_nr || nr_f !== e_nr) begin
                n_fail++; $display("FAIL rand_not_ready c%0d: got %b/%b want %b", c, nr_r, nr_f, e_nr);
            end
            for (int k = 0; k < N; k++) begin
                n_checks++;
                if (peob_r[k] !== ((e_disp && e_sel_r == k) ? d_eob : MIDDLE) ||
                    pseq_r[k] !== ((e_disp && e_sel_r == k) ? d_seq : SW'(0)) ||
                    peob_f[k] !== ((e_disp && e_sel_f == k) ? d_eob : MIDDLE) ||
                    pseq_f[k] !== ((e_disp && e_sel_f == k) ? d_seq : SW'(0))) begin
                    n_fail++; $display("FAIL rand_steer c%0d pipe%0d: got rr=%0d/%0d fx=%0d/%0d want rr_sel=%0d fx_sel=%0d disp=%b",
                                       c, k, peob_r[k], pseq_r[k], peob_f[k], pseq_f[k], e_sel_r, e_sel_f, e_disp);
                end
            end
            n_checks++;
            if (ov_r !== (q_seq.size() > 0) || ov_f !== (q_seq.size() > 0) ||
                (q_seq.size() > 0 && (int'(op_r) != qr_p[0] || int'(op_f) != qf_p[0] ||
                                      int'(os_r) != q_seq[0] || int'(os_f) != q_seq[0]))) begin
                n_fail++; $display("FAIL rand_order_head c%0d: got v=%b rr=(%0d,%0d) fx=(%0d,%0d) want depth %0d",
                                   c, ov_r, op_r, os_r, op_f, os_f, q_seq.size());
            end
            n_checks++;
            if (dbg_r !== m_dbg_r || dbg_f !== m_dbg_f || uf_r !== m_uf || uf_f !== m_uf) begin
                n_fail++; $display("FAIL rand_pulses c%0d: got dbg=%b/%b uf=%b want dbg=%b/%b uf=%b",
                                   c, dbg_r, dbg_f, uf_r, m_dbg_r, m_dbg_f, m_uf);
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0; in_eob = MIDDLE; in_seq_id = '0; ord_pop = 1'b0;
        pipe_not_ready = '0; sw_disable_mask = '0;
        @(posedge clk); #1;
        test_reset();
        test_rr_seq();
        test_fixed();
        test_mask();
        test_fill();
        test_underflow();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
